// File: rtl/matmul_sequencer.sv
// Job sequencer for the 3x3 matrix-multiply accelerator: loads W/X banks, steps the MAC array, unloads results.
// Optional abort input enabled by defining MATSEQ_ABORT_EN.
module matmul_sequencer #(
    parameter int unsigned DW   = 4,
    parameter int unsigned MAXD = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
`ifdef MATSEQ_ABORT_EN
    input  logic                      abort,
`endif
    input  logic [1:0]                row_w,
    input  logic [1:0]                col_w,
    input  logic [1:0]                row_x,
    input  logic [1:0]                col_x,
    input  logic [DW-1:0]             in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      mem_clear,
    output logic                      mem_we_w,
    output logic                      mem_we_x,
    output logic [3:0]                mem_addr,
    output logic [DW-1:0]             mem_wdata,
    output logic [1:0]                k_idx,
    output logic [MAXD*MAXD-1:0]      mac_ld,
    output logic [MAXD*MAXD-1:0]      mac_clear,
    output logic [3:0]                res_sel,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      busy,
    output logic                      err_dim,
    output logic                      done
);

    localparam int unsigned NMAC = MAXD * MAXD;
    localparam int unsigned AW   = 4;
    localparam int unsigned DIMW = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD_W,
        S_LOAD_X,
        S_COMPUTE,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DIMW-1:0]     row_w_q, row_w_d, col_w_q, col_w_d;
    logic [DIMW-1:0]     row_x_q, row_x_d, col_x_q, col_x_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [DIMW-1:0]     k_q, k_d;
    logic [DIMW-1:0]     i_q, i_d, j_q, j_d;
    logic                err_q, err_d;
    logic                aborting_q, aborting_d;

    logic                in_ready_q, in_ready_d;
    logic                mem_clear_q, mem_clear_d;
    logic                mem_we_w_q, mem_we_w_d;
    logic                mem_we_x_q, mem_we_x_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
    logic [NMAC-1:0]     mac_ld_q, mac_ld_d;
    logic [NMAC-1:0]     mac_clear_q, mac_clear_d;
    logic [AW-1:0]       res_sel_q, res_sel_d;
    logic                res_valid_q, res_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                accept_c;
    logic                dim_bad_c;
    logic                wr_ok_c;
    logic [AW-1:0]       n_w_c, n_x_c;
    logic [NMAC-1:0]     mask_c;

    // Active MAC set: rows of W by columns of X, row-major index i*MAXD+j
    always_comb begin
        mask_c = '0;
        for (int unsigned i = 0; i < MAXD; i++) begin
            for (int unsigned j = 0; j < MAXD; j++) begin
                mask_c[i*MAXD+j] = (i < 32'(row_w_q)) && (j < 32'(col_x_q));
            end
        end
    end

    assign accept_c  = in_valid && in_ready_q;
    assign n_w_c     = AW'(row_w_q) * AW'(col_w_q);
    assign n_x_c     = AW'(row_x_q) * AW'(col_x_q);
    assign dim_bad_c = (row_w == '0) || (col_w == '0) || (row_x == '0) ||
                       (col_x == '0) || (col_w != row_x);

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        row_w_d     = row_w_q;
        col_w_d     = col_w_q;
        row_x_d     = row_x_q;
        col_x_d     = col_x_q;
        cnt_d       = cnt_q;
        k_d         = '0;
        i_d         = '0;
        j_d         = '0;
        err_d       = err_q;
        aborting_d  = 1'b0;

        in_ready_d  = 1'b0;
        mem_clear_d = 1'b0;
        mem_we_w_d  = 1'b0;
        mem_we_x_d  = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mac_ld_d    = '0;
        mac_clear_d = '0;
        res_sel_d   = '0;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        wr_ok_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    if (dim_bad_c) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        row_w_d = row_w;
                        col_w_d = col_w;
                        row_x_d = row_x;
                        col_x_d = col_x;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = aborting_q ? S_IDLE : S_LOAD_W;
            end
            S_LOAD_W: begin
                if (accept_c) begin
                    if (cnt_q == n_w_c - AW'(1)) begin
                        cnt_d   = '0;
                        state_d = S_LOAD_X;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            S_LOAD_X: begin
                if (accept_c) begin
                    if (cnt_q == n_x_c - AW'(1)) begin
                        cnt_d   = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (k_q == col_w_q - DIMW'(1)) begin
                    state_d = S_UNLOAD;
                end else begin
                    k_d = k_q + DIMW'(1);
                end
            end
            S_UNLOAD: begin
                i_d = i_q;
                j_d = j_q;
                if (res_valid_q && res_ready) begin
                    if (j_q == col_x_q - DIMW'(1)) begin
                        j_d = '0;
                        if (i_q == row_w_q - DIMW'(1)) begin
                            i_d     = '0;
                            state_d = S_DONE;
                        end else begin
                            i_d = i_q + DIMW'(1);
                        end
                    end else begin
                        j_d = j_q + DIMW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef MATSEQ_ABORT_EN
        // Abort overrides every other transition; the CLEAR it forces returns to IDLE
        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_CLEAR;
            aborting_d = 1'b1;
            cnt_d      = '0;
            k_d        = '0;
            i_d        = '0;
            j_d        = '0;
        end
`endif

        // Outputs are registered, so they are decoded from the state being entered
        in_ready_d  = (state_d == S_LOAD_W) ||
                      ((state_d == S_LOAD_X) && (state_q == S_LOAD_X));
        wr_ok_c     = accept_c && (state_d != S_CLEAR);
        mem_we_w_d  = wr_ok_c && (state_q == S_LOAD_W);
        mem_we_x_d  = wr_ok_c && (state_q == S_LOAD_X);
        if (mem_we_w_d || mem_we_x_d) begin
            mem_addr_d  = cnt_q;
            mem_wdata_d = in_data;
        end
        mem_clear_d = (state_d == S_CLEAR);
        if (state_d == S_CLEAR) begin
            mac_clear_d = '1;
        end else if (state_d == S_COMPUTE) begin
            mac_ld_d    = mask_c;
            mac_clear_d = ~mask_c;
        end
        res_valid_d = (state_d == S_UNLOAD);
        if (state_d == S_UNLOAD) begin
            res_sel_d = AW'(i_d) * AW'(MAXD) + AW'(j_d);
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_w_q     <= '0;
            col_w_q     <= '0;
            row_x_q     <= '0;
            col_x_q     <= '0;
            cnt_q       <= '0;
            k_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            err_q       <= 1'b0;
            aborting_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_clear_q <= 1'b0;
            mem_we_w_q  <= 1'b0;
            mem_we_x_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mac_ld_q    <= '0;
            mac_clear_q <= '1;
            res_sel_q   <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_w_q     <= row_w_d;
            col_w_q     <= col_w_d;
            row_x_q     <= row_x_d;
            col_x_q     <= col_x_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            i_q         <= i_d;
            j_q         <= j_d;
            err_q       <= err_d;
            aborting_q  <= aborting_d;
            in_ready_q  <= in_ready_d;
            mem_clear_q <= mem_clear_d;
            mem_we_w_q  <= mem_we_w_d;
            mem_we_x_q  <= mem_we_x_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mac_ld_q    <= mac_ld_d;
            mac_clear_q <= mac_clear_d;
            res_sel_q   <= res_sel_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_clear = mem_clear_q;
    assign mem_we_w  = mem_we_w_q;
    assign mem_we_x  = mem_we_x_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign k_idx     = k_q;
    assign mac_ld    = mac_ld_q;
    assign mac_clear = mac_clear_q;
    assign res_sel   = res_sel_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign err_dim   = err_q;
    assign done      = done_q;

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
Central controller for the 3x3 matrix-multiply accelerator. Accepts a job (W and X dimensions), then streams W and X elements into the W/X memory banks. It steps the 9-MAC array through the k-dimension and streams results out through a valid/ready port. Sits between the host-side element stream and the memory bank / MAC array, replacing address-counter-driven sequencing with an explicit FSM.

Parameters:
DW, 4, element width (bits) of in_data / mem_wdata
MAXD, 3, maximum matrix dimension; fixes mem depth 9 and MAC count 9

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  job start pulse; sampled in IDLE only
row_w  input  2  rows of W (1..3)
col_w  input  2  cols of W (1..3)
row_x  input  2  rows of X (1..3)
col_x  input  2  cols of X (1..3)
in_data  input  DW  element stream, row-major, W first then X
in_valid  input  1  in_data valid
in_ready  output  1  sequencer accepts in_data this cycle
mem_clear  output  1  clear both memory banks
mem_we_w  output  1  write enable, W bank
mem_we_x  output  1  write enable, X bank
mem_addr  output  4  write address 0..8
mem_wdata  output  DW  write data (in_data, registered)
k_idx  output  2  current inner-product index for bank read-out
mac_ld  output  9  per-MAC accumulate enable, index i*3+j
mac_clear  output  9  per-MAC clear
res_sel  output  4  MAC index selected for result read-out
res_valid  output  1  result at res_sel is valid
res_ready  input  1  downstream accepts result
busy  output  1  high in any state except IDLE
err_dim  output  1  illegal dimensions flagged
done  output  1  one-cycle pulse at job completion

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except mac_clear=9'h1FF; counters, latched dims, err_dim cleared. Exit synchronously on the first clk edge after release.
- IDLE: in_ready=0. When start=1:
  - If any dim is 0 or col_w!=row_x: err_dim<=1, stay IDLE.
  - Otherwise latch dims, err_dim<=0, go CLEAR.
- start is ignored while busy.
- CLEAR (1 cycle): mem_clear=1, mac_clear=9'h1FF. Address counter <=0. Go LOAD_W.
- LOAD_W: in_ready=1. Each in_valid&in_ready cycle: next cycle mem_we_w=1, mem_addr=counter, mem_wdata=in_data (1-cycle write latency), counter+1.
  - After row_w*col_w accepts: counter<=0, go LOAD_X.
  - in_valid=0 stalls with no write.
- LOAD_X: identical, using mem_we_x and row_x*col_x elements. Then go COMPUTE with k=0.
  - in_ready=0 during the cycle the last element of each matrix is accepted +1 (state switch). No element may be lost across W->X.
- COMPUTE: one cycle per k, k_idx=k.
  - mac_ld[i*3+j]=1 iff i<row_w and j<col_x. Inactive MACs: mac_ld=0, mac_clear=1.
  - After k==col_w-1, go UNLOAD; latency = col_w cycles.
- UNLOAD: res_sel walks active MACs in row-major order (i*3+j), res_valid=1.
  - Advance only on res_valid&res_ready. res_sel/res_valid hold stable while res_ready=0.
  - After the last active MAC is accepted, go DONE.
- DONE (1 cycle): done=1, res_valid=0. Go IDLE. MAC contents retained until the next CLEAR.
- Element counts: row*col computed as 4-bit unsigned (max 9); no wrap possible.
- Reset mid-operation: immediate return to IDLE. Partial memory contents are don't-care; the next job's CLEAR wipes them.

Optional Feature:
MATSEQ_ABORT_EN: adds input port abort (1 bit).
- abort=1 in any non-IDLE state: next cycle go CLEAR for one cycle (mem_clear, mac_clear all set), then IDLE. No done pulse; err_dim unchanged.
- abort in IDLE: no effect. abort has priority over all other transitions.
- Without the macro: port absent, no abort path, FSM as above.

Test Plan:
- 2x2*2x2, stream 1,2,3,4 then 5,6,7,8, res_ready=1:
  - mem_we_w at addr 0..3, then mem_we_x at addr 0..3.
  - COMPUTE 2 cycles with mac_ld=9'h01B.
  - res_sel 0,1,3,4; done pulses once.
- 3x3*3x3, continuous in_valid:
  - 9+9 writes; 3 COMPUTE cycles with mac_ld=9'h1FF.
  - res_sel 0..8; busy falls the cycle after done.
- Dimension error, row_w=2 col_w=3 row_x=2 col_x=1, start:
  - err_dim=1, busy=0, no writes.
  - Then a legal start clears err_dim.
- 1x3*3x1 with in_valid toggling every other cycle and res_ready low for 3 cycles:
  - 3 COMPUTE cycles, only mac_ld[0]=1.
  - res_valid held with res_sel=0 until res_ready rises.
- rst_n pulled low mid-LOAD_X: outputs at reset values with no clk edge needed. A subsequent 2x2 job completes correctly.
- (MATSEQ_ABORT_EN) abort during COMPUTE k=1 of a 3x3 job:
  - One CLEAR cycle, then IDLE.
  - done never asserted; next job runs cleanly.
